// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 UART: parity modes, FSM state encodings
// and the parity helper used by both the transmitter and the receiver.
package rs232_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // Unused upper data bits must be zero so they do not disturb the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO: head visible while not empty, 1-cycle push/pop.
// Push is dropped when full unless a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Forcing zero while empty keeps the head output clean without resetting the array.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rs232_uart.sv
// Full-duplex UART with internal baud divider, optional parity, RX FIFO and sticky errors.
// TX line lags its FSM by one registered cycle; RX bytes are dropped with err_overrun when the FIFO is full.
module rs232_uart
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 8750,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               rx,
  output logic                               tx,
  input  logic [DATA_BITS-1:0]               tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic [DATA_BITS-1:0]               rx_data,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic [$clog2(RX_FIFO_DEPTH):0]     rx_level,
  output logic                               err_frame,
  output logic                               err_parity,
  output logic                               err_overrun,
  input  logic                               err_clear
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  // ---------------- transmitter ----------------
  tx_state_t             tx_state, tx_next;
  logic [CW-1:0]         tx_cnt;
  logic [2:0]            tx_idx;
  logic [DATA_BITS-1:0]  tx_shift;
  logic                  tx_par;
  logic                  tx_bit_done;
  logic                  tx_accept;

  assign tx_bit_done = (tx_cnt == BIT_LAST);
  assign tx_accept   = tx_valid & tx_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) tx_state <= TX_IDLE;
    else          tx_state <= tx_next;
  end

  always_comb begin
    tx_next  = tx_state;
    tx_ready = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) tx_next = TX_START;
      end
      TX_START:  if (tx_bit_done) tx_next = TX_DATA;
      TX_DATA:   if (tx_bit_done && tx_idx == DATA_LAST)
                   tx_next = (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_bit_done) tx_next = TX_STOP;
      TX_STOP: begin
        // Ready on the last stop cycle lets the next frame follow with no gap.
        if (tx_bit_done && tx_idx == STOP_LAST) begin
          tx_ready = 1'b1;
          tx_next  = tx_valid ? TX_START : TX_IDLE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      case (tx_state)
        TX_START:  tx <= 1'b0;
        TX_DATA:   tx <= tx_shift[0];
        TX_PARITY: tx <= tx_par;
        default:   tx <= 1'b1;
      endcase
      if (tx_accept) begin
        tx_shift <= tx_data;
        tx_par   <= parity_bit(8'(tx_data), PARITY);
      end else if (tx_state == TX_DATA && tx_bit_done) begin
        tx_shift <= tx_shift >> 1;
      end
      if (tx_state == TX_IDLE || tx_next != tx_state) begin
        tx_cnt <= '0;
        tx_idx <= '0;
      end else if (tx_bit_done) begin
        tx_cnt <= '0;
        tx_idx <= tx_idx + 1'b1;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t             rx_state, rx_next;
  logic                  rx_s1, rx_s2, rx_s3;
  logic [1:0]            rx_samp;
  logic [CW-1:0]         rx_cnt;
  logic [2:0]            rx_idx;
  logic [DATA_BITS-1:0]  rx_shift;
  logic                  rx_par_err;
  logic                  rx_bit;
  logic                  rx_bit_done;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                  set_frame, set_parity, set_overrun;

  assign rx_bit_done = (rx_cnt == BIT_LAST);
  // Majority vote over the last three synchronized samples around the bit centre.
  assign rx_bit   = (rx_samp[1] & rx_samp[0]) | (rx_samp[1] & rx_s2) | (rx_samp[0] & rx_s2);
  assign rx_valid = ~fifo_empty;
  assign fifo_pop = rx_valid & rx_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rx_state <= RX_IDLE;
    else          rx_state <= rx_next;
  end

  always_comb begin
    rx_next     = rx_state;
    fifo_push   = 1'b0;
    set_frame   = 1'b0;
    set_parity  = 1'b0;
    set_overrun = 1'b0;
    case (rx_state)
      RX_IDLE:   if (rx_s3 && !rx_s2) rx_next = RX_START;
      RX_START:  if (rx_cnt == HALF_BIT) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_bit_done && rx_idx == DATA_LAST)
                   rx_next = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_bit_done) rx_next = RX_STOP;
      RX_STOP: begin
        if (rx_bit_done) begin
          if (!rx_bit) begin
            set_frame = 1'b1;
            rx_next   = RX_BREAK;
          end else begin
            rx_next    = RX_IDLE;
            set_parity = rx_par_err;
            if (fifo_full && !fifo_pop) set_overrun = 1'b1;
            else                        fifo_push   = 1'b1;
          end
        end
      end
      RX_BREAK:  if (rx_s2) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_s3       <= 1'b1;
      rx_samp     <= 2'b11;
      rx_cnt      <= '0;
      rx_idx      <= '0;
      rx_shift    <= '0;
      rx_par_err  <= 1'b0;
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_s3   <= rx_s2;
      rx_samp <= {rx_samp[0], rx_s2};
      if (rx_state == RX_DATA && rx_bit_done)
        rx_shift <= {rx_bit, rx_shift[DATA_BITS-1:1]};
      if (rx_state == RX_PARITY && rx_bit_done)
        rx_par_err <= rx_bit ^ parity_bit(8'(rx_shift), PARITY);
      if (rx_state == RX_IDLE || rx_state == RX_BREAK || rx_next != rx_state) begin
        rx_cnt <= '0;
        rx_idx <= '0;
      end else if (rx_bit_done) begin
        rx_cnt <= '0;
        rx_idx <= rx_idx + 1'b1;
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
      // A fresh error on the clearing cycle keeps its flag set.
      err_frame   <= set_frame   | (err_frame   & ~err_clear);
      err_parity  <= set_parity  | (err_parity  & ~err_clear);
      err_overrun <= set_overrun | (err_overrun & ~err_clear);
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (rx_shift),
    .pop       (fifo_pop),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (rx_level)
  );

endmodule

// File: tb/tb_rs232_uart.sv
// Directed bench: 8N1 instance for TX timing and RX errors, 8E1 loopback instance,
// 8O1 instance for parity errors; all with 16 clocks per bit.
module tb_rs232_uart;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // Serial stimulus line, steered to instance a (sel=0) or c (sel=1).
  logic line;
  logic sel;

  logic       a_rx, a_tx, a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready;
  logic [7:0] a_tx_data, a_rx_data;
  logic [2:0] a_rx_level;
  logic       a_err_frame, a_err_parity, a_err_overrun, a_err_clear;

  logic       b_tx, b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready;
  logic [7:0] b_tx_data, b_rx_data;
  logic [2:0] b_rx_level;
  logic       b_err_frame, b_err_parity, b_err_overrun, b_err_clear;

  logic       c_rx, c_tx, c_tx_valid, c_tx_ready, c_rx_valid, c_rx_ready;
  logic [7:0] c_tx_data, c_rx_data;
  logic [2:0] c_rx_level;
  logic       c_err_frame, c_err_parity, c_err_overrun, c_err_clear;

  assign a_rx = (sel == 1'b0) ? line : 1'b1;
  assign c_rx = (sel == 1'b1) ? line : 1'b1;

  rs232_uart #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_a (
    .clock(clock), .reset_n(reset_n), .rx(a_rx), .tx(a_tx),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_level(a_rx_level),
    .err_frame(a_err_frame), .err_parity(a_err_parity), .err_overrun(a_err_overrun),
    .err_clear(a_err_clear));

  rs232_uart #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_b (
    .clock(clock), .reset_n(reset_n), .rx(b_tx), .tx(b_tx),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_level(b_rx_level),
    .err_frame(b_err_frame), .err_parity(b_err_parity), .err_overrun(b_err_overrun),
    .err_clear(b_err_clear));

  rs232_uart #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_c (
    .clock(clock), .reset_n(reset_n), .rx(c_rx), .tx(c_tx),
    .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
    .rx_data(c_rx_data), .rx_valid(c_rx_valid), .rx_ready(c_rx_ready), .rx_level(c_rx_level),
    .err_frame(c_err_frame), .err_parity(c_err_parity), .err_overrun(c_err_overrun),
    .err_clear(c_err_clear));

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [7:0] data; logic [9:0] frame; } tx_vec_t;  // frame[0] = start bit
  typedef struct { logic [7:0] data; logic [7:0] exp;   } lb_vec_t;

  tx_vec_t tv [4];
  lb_vec_t lv [4];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives bits[0] first, 16 clocks each, then leaves the line idle high.
  task automatic send_line(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      line = bits[i];
      repeat (16) tick();
    end
    line = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int errs, n;
    logic rdy158, rdy159;
    logic [7:0] got;

    tv[0] = '{8'hA5, 10'b1_10100101_0};
    tv[1] = '{8'h00, 10'b1_00000000_0};
    tv[2] = '{8'hFF, 10'b1_11111111_0};
    tv[3] = '{8'h3C, 10'b1_00111100_0};
    lv[0] = '{8'h00, 8'h00};
    lv[1] = '{8'hFF, 8'hFF};
    lv[2] = '{8'h3C, 8'h3C};
    lv[3] = '{8'h07, 8'h07};

    reset_n = 1'b0; line = 1'b1; sel = 1'b0;
    a_tx_data = '0; a_tx_valid = 0; a_rx_ready = 0; a_err_clear = 0;
    b_tx_data = '0; b_tx_valid = 0; b_rx_ready = 0; b_err_clear = 0;
    c_tx_data = '0; c_tx_valid = 0; c_rx_ready = 0; c_err_clear = 0;
    repeat (3) tick();

    check("reset_a", {a_tx, a_tx_ready, a_rx_valid, a_rx_data, a_rx_level, a_err_frame, a_err_parity, a_err_overrun},
          {1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 3'b000});
    check("reset_b", {b_tx, b_tx_ready, b_rx_valid, b_rx_data, b_rx_level, b_err_frame, b_err_parity, b_err_overrun},
          {1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 3'b000});
    reset_n = 1'b1;
    repeat (2) tick();

    // TX 8N1: every cycle of the 160-cycle frame checked against the hand-written frame.
    for (int v = 0; v < 4; v++) begin
      errs = 0; rdy158 = 1'bx; rdy159 = 1'bx;
      a_tx_data = tv[v].data; a_tx_valid = 1'b1;
      tick();
      a_tx_valid = 1'b0;
      for (int k = 1; k <= 160; k++) begin
        tick();
        if (a_tx !== tv[v].frame[(k-1)/16]) errs++;
        if (k == 158) rdy158 = a_tx_ready;
        if (k == 159) rdy159 = a_tx_ready;
      end
      check("tx_wave_bad_cycles", errs, 0);
      check("tx_ready_cycle158", rdy158, 1'b0);
      check("tx_ready_cycle159", rdy159, 1'b1);
    end

    // Loopback 8E1.
    for (int v = 0; v < 4; v++) begin
      b_tx_data = lv[v].data; b_tx_valid = 1'b1;
      n = 0;
      while (!b_tx_ready && n < 400) begin tick(); n++; end
      tick();
      b_tx_valid = 1'b0;
      n = 0;
      while (!b_rx_valid && n < 400) begin tick(); n++; end
      check("lb_rx_valid", b_rx_valid, 1'b1);
      check("lb_rx_data", b_rx_data, lv[v].exp);
      check("lb_errors", {b_err_frame, b_err_parity, b_err_overrun}, 3'b000);
      b_rx_ready = 1'b1; tick(); b_rx_ready = 1'b0;
      check("lb_popped", b_rx_valid, 1'b0);
    end

    // Stop bit forced low, line held low one more bit, then a clean 0x55.
    send_line({1'b0, 1'b0, 1'b0, 8'h12, 1'b0}, 11);
    check("frame_err_set", a_err_frame, 1'b1);
    check("frame_fifo_level", a_rx_level, 3'd0);
    repeat (20) tick();
    send_line({2'b00, 1'b1, 8'h55, 1'b0}, 10);
    check("after_break_valid", a_rx_valid, 1'b1);
    check("after_break_data", a_rx_data, 8'h55);
    a_rx_ready = 1'b1; tick(); a_rx_ready = 1'b0;
    a_err_clear = 1'b1; tick(); a_err_clear = 1'b0;
    check("frame_err_cleared", a_err_frame, 1'b0);

    // Quarter-bit low glitch must be rejected silently.
    line = 1'b0; repeat (4) tick(); line = 1'b1;
    repeat (48) tick();
    check("glitch_no_byte", {a_rx_valid, a_rx_level}, 4'b0000);
    check("glitch_no_flags", {a_err_frame, a_err_parity, a_err_overrun}, 3'b000);

    // Overrun: five frames with no pops into a 4-deep FIFO.
    send_line({2'b00, 1'b1, 8'h11, 1'b0}, 10);
    send_line({2'b00, 1'b1, 8'h22, 1'b0}, 10);
    send_line({2'b00, 1'b1, 8'h33, 1'b0}, 10);
    send_line({2'b00, 1'b1, 8'h44, 1'b0}, 10);
    check("ovr_full_level", a_rx_level, 3'd4);
    check("ovr_not_yet", a_err_overrun, 1'b0);
    send_line({2'b00, 1'b1, 8'h99, 1'b0}, 10);
    check("ovr_level", a_rx_level, 3'd4);
    check("ovr_flag", a_err_overrun, 1'b1);
    for (int i = 0; i < 4; i++) begin
      got = a_rx_data;
      a_rx_ready = 1'b1; tick(); a_rx_ready = 1'b0;
      case (i)
        0: check("ovr_head0", got, 8'h11);
        1: check("ovr_head1", got, 8'h22);
        2: check("ovr_head2", got, 8'h33);
        default: check("ovr_head3", got, 8'h44);
      endcase
    end
    check("ovr_drained", a_rx_level, 3'd0);

    // Odd parity on instance c: correct parity first, then a wrong parity bit.
    sel = 1'b1;
    send_line({1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    check("par_ok_level", c_rx_level, 3'd1);
    check("par_ok_flag", c_err_parity, 1'b0);
    send_line({1'b0, 1'b1, 1'b0, 8'h5A, 1'b0}, 11);
    check("par_bad_level", c_rx_level, 3'd2);
    check("par_bad_flag", c_err_parity, 1'b1);
    check("par_head0", c_rx_data, 8'h07);
    c_rx_ready = 1'b1; tick(); c_rx_ready = 1'b0;
    check("par_head1", c_rx_data, 8'h5A);
    c_err_clear = 1'b1; tick(); c_err_clear = 1'b0;
    check("par_cleared", c_err_parity, 1'b0);
    sel = 1'b0;

    // Reset asserted in the middle of a transmitted frame.
    a_tx_data = 8'h00; a_tx_valid = 1'b1;
    tick();
    a_tx_valid = 1'b0;
    repeat (40) tick();
    check("midtx_line_low", a_tx, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midtx_reset_tx", a_tx, 1'b1);
    tick();
    reset_n = 1'b1;
    tick();
    check("midtx_ready_after", {a_tx_ready, a_tx}, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
